// File: rtl/current_pkg.sv
// Shared types and frame geometry for the current ADC reader and the current monitor.
package current_pkg;

    localparam int unsigned FRAME_BITS     = 16;
    localparam int unsigned LEAD_ZERO_BITS = 4;
    localparam int unsigned DATA_BITS      = 12;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        DONE
    } adc_state_e;

    // A frame is good only when its leading bits are all zero.
    function automatic logic lead_ok(logic [FRAME_BITS-1:0] word);
        return word[FRAME_BITS-1 -: LEAD_ZERO_BITS] == '0;
    endfunction

endpackage

// File: rtl/current_adc_reader_if.sv
// SPI-style bus between the reader (master) and the ADC (slave).
interface current_adc_reader_if;

    logic adc_miso;
    logic adc_cs_n;
    logic adc_sclk;

    modport master (
        input  adc_miso,
        output adc_cs_n,
        output adc_sclk
    );

    modport slave (
        output adc_miso,
        input  adc_cs_n,
        input  adc_sclk
    );

endinterface

// File: rtl/adc_clk_div.sv
// Half-period tick generator: tick_o is high on the last cycle of every CLK_DIV-cycle window.
module adc_clk_div #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [7:0] LastCnt = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Wrap at the end of the window; clr_i realigns the window to a frame start.
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LastCnt) begin
            cnt_d = '0;
        end
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LastCnt);

endmodule

// File: rtl/current_adc_reader.sv
// Periodic 16-bit serial ADC reader: frames of 4 leading zeros + 12 data bits, MSB first.
module current_adc_reader
    import current_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 25,
    parameter int unsigned SAMPLE_PERIOD = 2000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    current_adc_reader_if.master       adc,
    output logic [DATA_BITS-1:0]       current_b_out,
    output logic                       sample_valid,
    output logic                       frame_err,
    output logic                       busy
);

    if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("CLK_DIV must be in 4..255");
    end
    if (SAMPLE_PERIOD < 34 * CLK_DIV + 2) begin : g_bad_period
        $error("SAMPLE_PERIOD must be at least 34*CLK_DIV+2");
    end

    localparam int unsigned PerW    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [PerW-1:0] LastPer  = PerW'(SAMPLE_PERIOD - 1);
    localparam logic [4:0]      LastHalf = 5'(2 * FRAME_BITS - 1);

    logic                  miso_meta_q;
    logic                  miso_sync_q;
    logic [PerW-1:0]       period_q, period_d;
    adc_state_e            state_q, state_d;
    logic [4:0]            half_q, half_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic [DATA_BITS-1:0]  current_q, current_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  frame_start;
    logic                  tick;

    assign frame_start = en && (period_q == '0) && (state_q == IDLE);

    adc_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (frame_start),
        .tick_o (tick)
    );

    // Two-flop synchronizer for the asynchronous MISO line.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= adc.adc_miso;
            miso_sync_q <= miso_meta_q;
        end
    end

    // Period counter runs only while enabled and parks at zero otherwise.
    always_comb begin
        period_d = '0;
        if (en) begin
            period_d = (period_q == LastPer) ? '0 : period_q + 1'b1;
        end
    end

    // Frame sequencing; half_q counts SCLK half-periods, even = high phase.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = CS_SETUP;
                    half_d  = '0;
                    shreg_d = '0;
                end
            end
            CS_SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    half_d  = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!half_q[0]) begin
                        shreg_d = {shreg_q[FRAME_BITS-2:0], miso_sync_q};
                    end
                    if (half_q == LastHalf) begin
                        state_d = CS_HOLD;
                    end else begin
                        half_d = half_q + 5'd1;
                    end
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state so the pins are registered and glitch-free.
    always_comb begin
        cs_n_d    = (state_d == IDLE) || (state_d == DONE);
        sclk_d    = (state_d == SHIFT) && !half_d[0];
        valid_d   = (state_q == DONE) && lead_ok(shreg_q);
        err_d     = (state_q == DONE) && !lead_ok(shreg_q);
        current_d = valid_d ? shreg_q[DATA_BITS-1:0] : current_q;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q  <= '0;
            state_q   <= IDLE;
            half_q    <= '0;
            shreg_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            current_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            period_q  <= period_d;
            state_q   <= state_d;
            half_q    <= half_d;
            shreg_q   <= shreg_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            current_q <= current_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign adc.adc_cs_n  = cs_n_q;
    assign adc.adc_sclk  = sclk_q;
    assign busy          = ~cs_n_q;
    assign current_b_out = current_q;
    assign sample_valid  = valid_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_current_adc_reader.sv
// Scoreboard bench for current_adc_reader with an SPI slave model driving on SCLK falls.
module tb_current_adc_reader;

    localparam int unsigned ClkDiv   = 4;
    localparam int unsigned Period   = 200;
    localparam int          FrameLat = 137;

    typedef struct {
        logic        is_err;
        logic [11:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [11:0] current_b_out;
    logic        sample_valid;
    logic        frame_err;
    logic        busy;

    current_adc_reader_if adc_bus ();

    current_adc_reader #(
        .CLK_DIV       (ClkDiv),
        .SAMPLE_PERIOD (Period)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .adc           (adc_bus.master),
        .current_b_out (current_b_out),
        .sample_valid  (sample_valid),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        exp_q[$];
    logic [15:0] model_q[$];
    int          fall_cyc_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_events = 0;
    int          n_falls  = 0;
    int          rise_cnt = 0;
    int          last_fall = 0;

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_events(int target, int budget, string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_events >= target) break;
        end
        check(name, n_events, target);
    endtask

    // Waits for a new chip-select fall, then for SCLK low after the given number of rises.
    task automatic wait_rises(int rises, string name);
        int nf;
        int ok;
        nf = n_falls;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (n_falls > nf && rise_cnt >= rises && !adc_bus.adc_sclk) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    initial begin
        int rel_cyc;
        int nf;
        exp_t e;
        adc_bus.adc_miso = 1'b0;
        fork
            begin : model
                logic [15:0] word;
                int          idx;
                logic        pcs;
                logic        psclk;
                word  = '0;
                idx   = 0;
                pcs   = 1'b1;
                psclk = 1'b0;
                forever begin
                    @(negedge clk);
                    if (pcs && !adc_bus.adc_cs_n) begin
                        word = 16'h0000;
                        if (model_q.size() > 0) word = model_q.pop_front();
                        adc_bus.adc_miso = word[15];
                        idx = 14;
                    end else if (psclk && !adc_bus.adc_sclk && !adc_bus.adc_cs_n) begin
                        adc_bus.adc_miso = word[idx];
                        if (idx > 0) idx--;
                    end
                    pcs   = adc_bus.adc_cs_n;
                    psclk = adc_bus.adc_sclk;
                end
            end
            begin : monitor
                logic pcs;
                logic psclk;
                exp_t m;
                pcs   = 1'b1;
                psclk = 1'b0;
                forever begin
                    @(negedge clk);
                    if (pcs && !adc_bus.adc_cs_n) begin
                        rise_cnt  = 0;
                        last_fall = cyc;
                        n_falls++;
                        fall_cyc_q.push_back(cyc);
                    end
                    if (!psclk && adc_bus.adc_sclk && !adc_bus.adc_cs_n) rise_cnt++;
                    check("busy_vs_cs_n", int'(busy), int'(!adc_bus.adc_cs_n));
                    if (sample_valid || frame_err) begin
                        check("pulse_exclusive", int'(sample_valid & frame_err), 0);
                        check("pulse_expected", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            m = exp_q.pop_front();
                            check("pulse_kind_err", int'(frame_err), int'(m.is_err));
                            check("current_b_out", int'(current_b_out), int'(m.value));
                            check("pulse_latency", cyc - last_fall, FrameLat);
                            check("sclk_rises", rise_cnt, 16);
                        end
                        n_events++;
                    end
                    pcs   = adc_bus.adc_cs_n;
                    psclk = adc_bus.adc_sclk;
                end
            end
        join_none

        // Reset state.
        repeat (5) @(negedge clk);
        check("rst_cs_n", int'(adc_bus.adc_cs_n), 1);
        check("rst_sclk", int'(adc_bus.adc_sclk), 0);
        check("rst_current", int'(current_b_out), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);

        // First frame plus three periodic frames.
        model_q.push_back(16'h09C4);
        model_q.push_back(16'h0000);
        model_q.push_back(16'h0FFF);
        model_q.push_back(16'h0800);
        e.is_err = 1'b0; e.value = 12'h9C4; exp_q.push_back(e);
        e.is_err = 1'b0; e.value = 12'h000; exp_q.push_back(e);
        e.is_err = 1'b0; e.value = 12'hFFF; exp_q.push_back(e);
        e.is_err = 1'b0; e.value = 12'h800; exp_q.push_back(e);
        rel_cyc = cyc;
        en  = 1'b1;
        rst = 1'b0;
        wait_events(4, 1000, "periodic_frames_done");
        check("first_start_delay", fall_cyc_q.size() > 0 ? fall_cyc_q[0] - rel_cyc : -1, 1);
        for (int i = 1; i < 4; i++) begin
            check("frame_spacing", fall_cyc_q.size() > i ? fall_cyc_q[i] - fall_cyc_q[i-1] : -1,
                  Period);
        end

        // Leading-bit error keeps the previous sample.
        model_q.push_back(16'h89C4);
        e.is_err = 1'b1; e.value = 12'h800; exp_q.push_back(e);
        wait_events(5, 400, "err_frame_done");
        en = 1'b0;
        check("err_frame_spacing", fall_cyc_q.size() > 4 ? fall_cyc_q[4] - fall_cyc_q[3] : -1,
              Period);
        check("err_current_held", int'(current_b_out), 12'h800);

        // Reset mid-frame after the 7th SCLK.
        repeat (10) @(negedge clk);
        model_q.push_back(16'h0123);
        en = 1'b1;
        wait_rises(7, "reach_7th_sclk");
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        check("midrst_cs_n", int'(adc_bus.adc_cs_n), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_current", int'(current_b_out), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("midrst_no_pulse", n_events, 5);

        // en dropped during SHIFT: frame completes, nothing follows.
        model_q.push_back(16'h0ABC);
        e.is_err = 1'b0; e.value = 12'hABC; exp_q.push_back(e);
        en = 1'b1;
        wait_rises(3, "reach_3rd_sclk");
        en = 1'b0;
        wait_events(6, 300, "endrop_frame_done");
        nf = n_falls;
        repeat (1000) @(negedge clk);
        check("endrop_no_new_frame", n_falls, nf);
        check("endrop_current", int'(current_b_out), 12'hABC);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
